// File: rtl/piso_shift_register_if.sv
// Handshake bundle for the parallel-in / serial-out shift register: a parallel
// load channel on one side and a serial output channel on the other.
interface piso_shift_register_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
);
    // Both channels use valid/ready: a beat transfers on a rising clock edge
    // where valid and ready are both high; valid, once raised, is held with
    // stable data until that edge; ready may depend combinationally on the
    // other side's ready, but never on valid.
    logic                   load_valid;
    logic                   load_ready;
    logic [WIDTH*DEPTH-1:0] load_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic                   out_last;

    modport master (
        output load_valid, load_data, out_ready,
        input  load_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  load_valid, load_data, out_ready,
        output load_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/piso_shift_register.sv
// Loads DEPTH elements of WIDTH bits in one beat, then sends them oldest-first,
// one per accepted output beat; a new load may overlap the final beat.
module piso_shift_register #(
    parameter int               WIDTH = 2,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                      real_clk,
    input  logic                      real_rst,
    piso_shift_register_if.slave      bus,
    output logic                      busy
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] stage [DEPTH];
    logic [CW-1:0]    count;
    logic             load_fire;
    logic             out_fire;

    assign load_fire    = bus.load_valid & bus.load_ready;
    assign out_fire     = bus.out_valid & bus.out_ready;
    assign bus.out_data = stage[0];

    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_fire) state_next = SHIFT;
            SHIFT:   if (out_fire && bus.out_last && !load_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // load_ready only looks at out_ready, so a reload on the last beat is bubble-free.
    always_comb begin
        bus.out_valid  = 1'b0;
        bus.out_last   = 1'b0;
        bus.load_ready = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                bus.load_ready = 1'b1;
            end
            SHIFT: begin
                bus.out_valid  = 1'b1;
                bus.out_last   = (count == CW'(1));
                bus.load_ready = (count == CW'(1)) & bus.out_ready;
                busy           = 1'b1;
            end
            default: ;
        endcase
    end

    // A load wins over the shift: on a coincident last beat the old element is
    // the one leaving, and the stages are refilled wholesale anyway.
    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= INIT;
            count <= '0;
        end else if (load_fire) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= bus.load_data[k*WIDTH +: WIDTH];
            count <= CW'(DEPTH);
        end else if (out_fire) begin
            for (int k = 0; k < DEPTH - 1; k++) stage[k] <= stage[k+1];
            stage[DEPTH-1] <= INIT;
            count          <= count - CW'(1);
        end
    end
endmodule
